// File: rtl/mc_bus_pkg.sv
// Shared widths, defaults and the FSM state type for the MCU bus responder.
package mc_bus_pkg;

  localparam int MC_DATA_WIDTH = 16;
  localparam int MC_ADD_WIDTH  = 6;
  localparam int MC_RD_TIMEOUT = 8;
  localparam logic [MC_DATA_WIDTH-1:0] MC_TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ_WAIT  = 3'd2,
    READ_DRIVE = 3'd3,
    ERROR      = 3'd4
  } mc_state_e;

endpackage

// File: rtl/mc_sync2.sv
// Two-flop synchronizer with a configurable reset value, used for the
// asynchronous MCU strobes (preset to 1 so the strobes start out inactive).
module mc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability flop followed by the output flop; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mc_bus_responder.sv
// MCU asynchronous parallel bus responder.
// Synchronizes the active-low strobes, turns each MCU write into a single
// wr_stb pulse and each MCU read into a rd_req / rd_valid exchange whose data
// is driven back onto the pad. Build option MC_CE_QUALIFY_EN makes mc_ce_n
// qualify strobes and abort transactions; without it mc_ce_n is ignored.
//
// Handshake: rd_req pulses once per read; rd_valid/rd_data are accepted in the
// rd_req cycle or any later cycle while waiting. rd_done pulses once when the
// MCU releases mc_oe_n (or the read is aborted) and serves as the FIFO pop.
module mc_bus_responder
  import mc_bus_pkg::*;
#(
  parameter int               DW           = MC_DATA_WIDTH,
  parameter int               AW           = MC_ADD_WIDTH,
  parameter int               RD_TIMEOUT   = MC_RD_TIMEOUT,
  parameter logic [DW-1:0]    TIMEOUT_DATA = MC_TIMEOUT_DATA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mc_ce_n,
  input  logic          mc_we_n,
  input  logic          mc_oe_n,
  input  logic [AW-1:0] mc_add,
  input  logic [DW-1:0] mc_data_in,
  output logic [DW-1:0] mc_data_out,
  output logic          mc_data_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_valid,
  input  logic [DW-1:0] rd_data,
  output logic          rd_done,
  output logic          err_stb,
  output mc_state_e     dbg_state
);

  localparam logic [3:0] TO_LAST = 4'(RD_TIMEOUT - 1);

  logic we_s, oe_s, ce_s, act;
  logic we_prev, oe_prev, we_fall, oe_fall;
  logic [3:0] cnt, cnt_n;
  mc_state_e state, state_n;
  logic wr_stb_n, rd_req_n, rd_done_n, err_stb_n, data_oe_n;
  logic [AW-1:0] wr_addr_n, rd_addr_n;
  logic [DW-1:0] wr_data_n, data_out_n;

  mc_sync2 #(.RST_VAL(1'b1)) u_sync_we (.clk(clk), .rst(rst), .d(mc_we_n), .q(we_s));
  mc_sync2 #(.RST_VAL(1'b1)) u_sync_oe (.clk(clk), .rst(rst), .d(mc_oe_n), .q(oe_s));
  mc_sync2 #(.RST_VAL(1'b1)) u_sync_ce (.clk(clk), .rst(rst), .d(mc_ce_n), .q(ce_s));

`ifdef MC_CE_QUALIFY_EN
  assign act = ~ce_s;
`else
  logic unused_ce;
  assign unused_ce = ce_s;
  assign act = 1'b1;
`endif

  assign dbg_state = state;

  // Registered falling-edge detect on the synchronized strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_prev <= 1'b1;
      oe_prev <= 1'b1;
      we_fall <= 1'b0;
      oe_fall <= 1'b0;
    end else begin
      we_prev <= we_s;
      oe_prev <= oe_s;
      we_fall <= we_prev & ~we_s;
      oe_fall <= oe_prev & ~oe_s;
    end
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      rd_done     <= 1'b0;
      err_stb     <= 1'b0;
      mc_data_out <= '0;
      mc_data_oe  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wr_stb      <= wr_stb_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      rd_req      <= rd_req_n;
      rd_addr     <= rd_addr_n;
      rd_done     <= rd_done_n;
      err_stb     <= err_stb_n;
      mc_data_out <= data_out_n;
      mc_data_oe  <= data_oe_n;
    end
  end

  // Next-state and next-output logic; pulses default low, latches hold.
  always_comb begin
    state_n    = state;
    cnt_n      = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    wr_stb_n   = 1'b0;
    rd_req_n   = 1'b0;
    rd_done_n  = 1'b0;
    err_stb_n  = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    rd_addr_n  = rd_addr;
    data_out_n = mc_data_out;
    data_oe_n  = mc_data_oe;
    case (state)
      IDLE: begin
        // Counter is held clear here so it starts at zero in READ_WAIT.
        cnt_n = '0;
        if (!we_s && !oe_s) begin
          err_stb_n = 1'b1;
          state_n   = ERROR;
        end else if (we_fall && oe_s && act) begin
          wr_addr_n = mc_add;
          wr_data_n = mc_data_in;
          wr_stb_n  = 1'b1;
          state_n   = WRITE;
        end else if (oe_fall && we_s && act) begin
          rd_addr_n = mc_add;
          rd_req_n  = 1'b1;
          state_n   = READ_WAIT;
        end
      end
      WRITE: begin
        if (!act || we_s) state_n = IDLE;
      end
      READ_WAIT: begin
        if (!act || oe_s) begin
          rd_done_n = 1'b1;
          state_n   = IDLE;
        end else if (rd_valid) begin
          data_out_n = rd_data;
          data_oe_n  = 1'b1;
          state_n    = READ_DRIVE;
        end else if (cnt == TO_LAST) begin
          data_out_n = TIMEOUT_DATA;
          data_oe_n  = 1'b1;
          err_stb_n  = 1'b1;
          state_n    = READ_DRIVE;
        end
      end
      READ_DRIVE: begin
        if (!act || oe_s) begin
          data_oe_n = 1'b0;
          rd_done_n = 1'b1;
          state_n   = IDLE;
        end
      end
      ERROR: begin
        if (we_s && oe_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/mc_bus_responder.md
Name: mc_bus_responder

Overview:
- FPGA-side responder for the MCU asynchronous parallel bus: active-low mc_we/mc_oe/mc_ce strobes, 6-bit mc_add, 16-bit mc_data.
- Synchronizes the strobes into clk and converts each MCU write into a single-cycle internal write strobe.
- Converts each MCU read into an internal read request/response and drives read data back onto the bus.
- Sits between the top-level pads (bidirectional data I/O cells live in top) and the register file / FIFO ports of the Bus Pirate core.

Parameters:
- DW, 16, bus data width
- AW, 6, bus address width
- RD_TIMEOUT, 8, clk cycles READ_WAIT waits for rd_valid before substituting TIMEOUT_DATA
- TIMEOUT_DATA, 16'hFFFF, value driven on read timeout

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- mc_ce_n  in  1  MCU chip enable, active low
- mc_we_n  in  1  MCU write strobe, active low
- mc_oe_n  in  1  MCU output enable (read), active low
- mc_add  in  AW  MCU address
- mc_data_in  in  DW  data from pad
- mc_data_out  out  DW  data to pad
- mc_data_oe  out  1  pad output enable; 1 = FPGA drives bus
- wr_stb  out  1  one-cycle write pulse
- wr_addr  out  AW  latched write address
- wr_data  out  DW  latched write data
- rd_req  out  1  one-cycle read request
- rd_addr  out  AW  latched read address
- rd_valid  in  1  read data valid (same or later cycle as rd_req)
- rd_data  in  DW  read data
- rd_done  out  1  one-cycle pulse when the MCU releases mc_oe_n; used as FIFO pop
- err_stb  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (rst=0, async):
  - all outputs 0, including mc_data_oe=0 (bus released immediately, including mid-read)
  - state IDLE
  - synchronizer flops preset to 1 (strobes inactive)
- Synchronization:
  - mc_we_n, mc_oe_n and mc_ce_n each pass through a 2-flop synchronizer, giving we_s, oe_s, ce_s.
  - mc_add and mc_data_in are sampled unsynchronized, only in the cycle the strobe edge is detected.
  - The MCU holds address and data stable ≥4 clk around the strobe.
- Active qualifier: act = 1 (see Optional Feature).
- IDLE:
  - we_s falls (prev 1, now 0), oe_s=1, act → capture wr_addr/wr_data; wr_stb=1 next cycle for exactly 1 cycle; go WRITE.
  - oe_s falls, we_s=1, act → capture rd_addr; rd_req=1 for 1 cycle; go READ_WAIT.
  - we_s=0 and oe_s=0 in the same cycle → err_stb 1 cycle; go ERROR.
- Write latency: wr_stb is high in the 4th clk cycle after the first rising edge that samples mc_we_n=0 (2 sync + 1 edge detect + 1 register).
- WRITE: stay until we_s=1 → IDLE. One wr_stb per strobe, regardless of length.
- READ_WAIT:
  - rd_valid=1 → mc_data_out=rd_data, mc_data_oe=1 next cycle; go READ_DRIVE.
  - RD_TIMEOUT cycles elapse without rd_valid → mc_data_out=TIMEOUT_DATA, mc_data_oe=1, err_stb 1 cycle; go READ_DRIVE.
  - oe_s returns to 1 before data → mc_data_oe stays 0, rd_done pulse; go IDLE.
- READ_DRIVE:
  - hold mc_data_out stable.
  - on oe_s=1 → mc_data_oe=0 in the same edge; rd_done 1 cycle; go IDLE.
  - mc_data_oe falls 2–3 clk after the pin rises; the MCU allows this bus-turnaround.
- ERROR: wait until we_s=1 and oe_s=1 → IDLE. No wr_stb, rd_req or rd_done is generated.
- Back-to-back transactions: a new strobe edge is only recognized from IDLE. A strobe already low on entry to IDLE is ignored, since edge detection is required.
- Timeout counter: 4 bits, saturating, cleared on entry to READ_WAIT.

Optional Feature:
- Macro: MC_CE_QUALIFY_EN.
- Defined: act = ~ce_s. Strobe edges while ce_s=1 are ignored. ce_s rising during WRITE/READ_WAIT/READ_DRIVE → release bus, rd_done if a read was in progress, go IDLE.
- Undefined: mc_ce_n ignored entirely, act=1. This is for boards with CE tied low or floating.

Decomposition:
- Package mc_bus_pkg holds:
  - MC_DATA_WIDTH=16, MC_ADD_WIDTH=6
  - state enum {IDLE, WRITE, READ_WAIT, READ_DRIVE, ERROR}
  - TIMEOUT_DATA default
- One sub-module, mc_sync2: a 2-flop synchronizer with reset preset value, instantiated three times.

Test Plan:
- Write: mc_add=0x19, data=0x0003, mc_we_n low 6 clk → exactly one wr_stb, wr_addr=0x19, wr_data=0x0003; no rd_req.
- Write sequence: four writes to 0x00 of 0x0055, 0x0020, 0x0202, 0x0303 → four wr_stb pulses, in order, with matching wr_data.
- Read: mc_add=0x00, mc_oe_n low 12 clk, rd_valid 2 clk after rd_req with rd_data=0x0055 → mc_data_oe=1, mc_data_out=0x0055 stable; mc_data_oe=0 and rd_done=1 within 3 clk of mc_oe_n rising.
- Timeout: read with rd_valid held 0 → after 8 cycles err_stb=1, mc_data_out=0xFFFF driven until mc_oe_n rises.
- Error and reset: mc_we_n and mc_oe_n low together → err_stb 1 pulse, no wr_stb/rd_req. Separately, assert rst low during READ_DRIVE → mc_data_oe=0 immediately and all outputs 0.
- CE (with MC_CE_QUALIFY_EN): mc_ce_n=1 with a write strobe → no wr_stb. Without the macro, the same stimulus → one wr_stb.
